// File: rtl/zap_cache_line_mover.sv
// Moves one 128-bit cache line between the line RAM and a 32-bit Wishbone bus:
// 4-beat burst read into the RAM (fill) or RAM read then 4-beat burst write (evict).
//
// state  | meaning
// IDLE   | waiting for a request, evict has priority over fill
// FILL   | Wishbone read burst, each acked beat written to RAM next cycle
// EV_RD  | RAM read issued for the victim entry
// EV_CAP | RAM data valid, captured into the line buffer
// EV_WR  | Wishbone write burst from the line buffer
// DONE   | one-cycle o_done pulse, then back to IDLE
module zap_cache_line_mover #(
   parameter int DEPTH = 32,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_fill_req,
   input  logic [27:0]    i_fill_adr,
   input  logic [IW-1:0]  i_fill_idx,
   input  logic           i_evict_req,
   input  logic [27:0]    i_evict_adr,
   input  logic [IW-1:0]  i_evict_idx,
   output logic           o_busy,
   output logic           o_done,
   output logic [15:0]    o_ram_ben,
   output logic [IW-1:0]  o_ram_waddr,
   output logic [127:0]   o_ram_wdata,
   output logic           o_ram_ren,
   output logic [IW-1:0]  o_ram_raddr,
   input  logic [127:0]   i_ram_rdata,
   output logic           o_wb_cyc,
   output logic           o_wb_stb,
   output logic           o_wb_we,
   output logic [31:0]    o_wb_adr,
   output logic [3:0]     o_wb_sel,
   output logic [31:0]    o_wb_dat,
   output logic [2:0]     o_wb_cti,
   output logic [1:0]     o_wb_bte,
   input  logic           i_wb_ack,
   input  logic [31:0]    i_wb_dat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_EV_RD,
      S_EV_CAP,
      S_EV_WR,
      S_DONE
   } state_t;

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_END  = 3'b111;

   state_t         state, state_nxt;
   logic [1:0]     beat, beat_nxt;
   logic [27:0]    line, line_nxt;
   logic [IW-1:0]  idx, idx_nxt;
   logic [127:0]   lbuf, lbuf_nxt;

   logic           busy_nxt, done_nxt, ren_nxt;
   logic [15:0]    ben_nxt;
   logic [IW-1:0]  waddr_nxt, raddr_nxt;
   logic [127:0]   wdata_nxt;
   logic           cyc_nxt, stb_nxt, we_nxt;
   logic [31:0]    adr_nxt, dat_nxt;
   logic [3:0]     sel_nxt;
   logic [2:0]     cti_nxt;

   logic [1:0]     nxt_beat;
   logic           ack;

   assign o_wb_bte = 2'b00;

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      line_nxt  = line;
      idx_nxt   = idx;
      lbuf_nxt  = lbuf;
      busy_nxt  = o_busy;
      done_nxt  = 1'b0;
      ren_nxt   = 1'b0;
      ben_nxt   = 16'h0000;
      waddr_nxt = o_ram_waddr;
      wdata_nxt = o_ram_wdata;
      raddr_nxt = o_ram_raddr;
      cyc_nxt   = o_wb_cyc;
      stb_nxt   = o_wb_stb;
      we_nxt    = o_wb_we;
      adr_nxt   = o_wb_adr;
      dat_nxt   = o_wb_dat;
      sel_nxt   = o_wb_sel;
      cti_nxt   = o_wb_cti;
      nxt_beat  = beat + 2'd1;
      ack       = i_wb_ack & o_wb_cyc;

      case (state)
         S_IDLE: begin
            if (i_evict_req) begin
               state_nxt = S_EV_RD;
               line_nxt  = i_evict_adr;
               idx_nxt   = i_evict_idx;
               beat_nxt  = 2'd0;
               busy_nxt  = 1'b1;
               ren_nxt   = 1'b1;
               raddr_nxt = i_evict_idx;
            end else if (i_fill_req) begin
               state_nxt = S_FILL;
               line_nxt  = i_fill_adr;
               idx_nxt   = i_fill_idx;
               beat_nxt  = 2'd0;
               busy_nxt  = 1'b1;
               cyc_nxt   = 1'b1;
               stb_nxt   = 1'b1;
               we_nxt    = 1'b0;
               sel_nxt   = 4'hF;
               adr_nxt   = {i_fill_adr, 4'h0};
               cti_nxt   = CTI_INCR;
               dat_nxt   = 32'h0;
            end
         end

         S_FILL: begin
            if (ack) begin
               ben_nxt   = 16'h000F << {beat, 2'b00};
               waddr_nxt = idx;
               wdata_nxt = {4{i_wb_dat}};
               beat_nxt  = nxt_beat;
               if (beat == 2'd3) begin
                  state_nxt = S_DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  cyc_nxt   = 1'b0;
                  stb_nxt   = 1'b0;
                  sel_nxt   = 4'h0;
                  cti_nxt   = 3'b000;
                  adr_nxt   = 32'h0;
               end else begin
                  adr_nxt = {line, nxt_beat, 2'b00};
                  cti_nxt = (nxt_beat == 2'd3) ? CTI_END : CTI_INCR;
               end
            end
         end

         S_EV_RD: begin
            state_nxt = S_EV_CAP;
         end

         S_EV_CAP: begin
            // RAM data is valid now; beat 0 goes straight out while the buffer loads
            lbuf_nxt  = i_ram_rdata;
            state_nxt = S_EV_WR;
            cyc_nxt   = 1'b1;
            stb_nxt   = 1'b1;
            we_nxt    = 1'b1;
            sel_nxt   = 4'hF;
            adr_nxt   = {line, 4'h0};
            cti_nxt   = CTI_INCR;
            dat_nxt   = i_ram_rdata[31:0];
         end

         S_EV_WR: begin
            if (ack) begin
               beat_nxt = nxt_beat;
               if (beat == 2'd3) begin
                  state_nxt = S_DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  cyc_nxt   = 1'b0;
                  stb_nxt   = 1'b0;
                  we_nxt    = 1'b0;
                  sel_nxt   = 4'h0;
                  cti_nxt   = 3'b000;
                  adr_nxt   = 32'h0;
                  dat_nxt   = 32'h0;
               end else begin
                  adr_nxt = {line, nxt_beat, 2'b00};
                  cti_nxt = (nxt_beat == 2'd3) ? CTI_END : CTI_INCR;
                  dat_nxt = lbuf[{nxt_beat, 5'd0} +: 32];
               end
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= S_IDLE;
         beat        <= 2'd0;
         line        <= 28'h0;
         idx         <= '0;
         lbuf        <= 128'h0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_ram_ben   <= 16'h0;
         o_ram_waddr <= '0;
         o_ram_wdata <= 128'h0;
         o_ram_ren   <= 1'b0;
         o_ram_raddr <= '0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_adr    <= 32'h0;
         o_wb_sel    <= 4'h0;
         o_wb_dat    <= 32'h0;
         o_wb_cti    <= 3'b000;
      end else begin
         state       <= state_nxt;
         beat        <= beat_nxt;
         line        <= line_nxt;
         idx         <= idx_nxt;
         lbuf        <= lbuf_nxt;
         o_busy      <= busy_nxt;
         o_done      <= done_nxt;
         o_ram_ben   <= ben_nxt;
         o_ram_waddr <= waddr_nxt;
         o_ram_wdata <= wdata_nxt;
         o_ram_ren   <= ren_nxt;
         o_ram_raddr <= raddr_nxt;
         o_wb_cyc    <= cyc_nxt;
         o_wb_stb    <= stb_nxt;
         o_wb_we     <= we_nxt;
         o_wb_adr    <= adr_nxt;
         o_wb_sel    <= sel_nxt;
         o_wb_dat    <= dat_nxt;
         o_wb_cti    <= cti_nxt;
      end
   end

endmodule

// File: tb/tb_zap_cache_line_mover.sv
// Bench for zap_cache_line_mover: table of transfers with a Wishbone slave, line RAM model
// and scoreboard queues of expected beats, RAM writes and RAM reads.
module tb_zap_cache_line_mover;

   localparam int DEPTH = 32;
   localparam int IW    = 5;

   logic           i_clk = 1'b0;
   logic           i_reset_n;
   logic           i_fill_req, i_evict_req;
   logic [27:0]    i_fill_adr, i_evict_adr;
   logic [IW-1:0]  i_fill_idx, i_evict_idx;
   logic           o_busy, o_done, o_ram_ren;
   logic [15:0]    o_ram_ben;
   logic [IW-1:0]  o_ram_waddr, o_ram_raddr;
   logic [127:0]   o_ram_wdata, i_ram_rdata;
   logic           o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack;
   logic [31:0]    o_wb_adr, o_wb_dat, i_wb_dat;
   logic [3:0]     o_wb_sel;
   logic [2:0]     o_wb_cti;
   logic [1:0]     o_wb_bte;

   zap_cache_line_mover #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_fill_req(i_fill_req), .i_fill_adr(i_fill_adr), .i_fill_idx(i_fill_idx),
      .i_evict_req(i_evict_req), .i_evict_adr(i_evict_adr), .i_evict_idx(i_evict_idx),
      .o_busy(o_busy), .o_done(o_done),
      .o_ram_ben(o_ram_ben), .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata),
      .o_ram_ren(o_ram_ren), .o_ram_raddr(o_ram_raddr), .i_ram_rdata(i_ram_rdata),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
      .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat), .o_wb_cti(o_wb_cti), .o_wb_bte(o_wb_bte),
      .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [2:0]  cti;
      logic [31:0] rdat;
   } beat_t;

   typedef struct {
      logic [15:0]   ben;
      logic [IW-1:0] waddr;
      logic [127:0]  wdata;
   } ramw_t;

   typedef struct {
      logic          is_ev;
      logic [27:0]   adr;
      logic [IW-1:0] idx;
      logic [127:0]  data;
      logic [15:0]   waits;   // wait cycles before each beat's ack, one nibble per beat
      int            lat;     // request cycle to o_done, in cycles
      logic          poke;    // pulse both requests while busy
   } vec_t;

   beat_t          exp_beats[$];
   ramw_t          exp_ram[$];
   logic [IW-1:0]  exp_raddr[$];
   int             wq[$];
   logic [127:0]   mem [DEPTH];

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int wcnt     = -1;
   bit hold_v   = 1'b0;
   bit stray    = 1'b0;
   logic [31:0] h_adr, h_dat;
   logic [2:0]  h_cti;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic miss(input string name, input logic [127:0] act);
      n_checks++;
      $display("FAIL %s: got unexpected %0h, required nothing", name, act);
   endtask

   // Wishbone slave, line RAM model and scoreboard, all sampled on the falling edge
   initial begin : mon
      beat_t        be;
      ramw_t        re;
      logic         rd_pend;
      logic [IW-1:0] rd_addr;
      rd_pend = 1'b0;
      rd_addr = '0;
      forever begin
         @(negedge i_clk);
         if (rd_pend) begin
            i_ram_rdata = mem[rd_addr];
            rd_pend = 1'b0;
         end else begin
            i_ram_rdata = {4{32'hBAD0_BAD0}};
         end
         if (o_ram_ren) begin
            rd_pend = 1'b1;
            rd_addr = o_ram_raddr;
            if (exp_raddr.size() == 0) miss("ram_read_extra", o_ram_raddr);
            else chk("ram_raddr", o_ram_raddr, exp_raddr.pop_front());
         end
         if (o_ram_ben != 16'h0) begin
            for (int b = 0; b < 16; b++)
               if (o_ram_ben[b]) mem[o_ram_waddr][8*b +: 8] = o_ram_wdata[8*b +: 8];
            if (exp_ram.size() == 0) miss("ram_write_extra", o_ram_ben);
            else begin
               re = exp_ram.pop_front();
               chk("ram_ben", o_ram_ben, re.ben);
               chk("ram_waddr", o_ram_waddr, re.waddr);
               chk("ram_wdata", o_ram_wdata, re.wdata);
            end
         end
         if (o_done) done_cnt++;
         if (o_wb_cyc && o_wb_stb) begin
            if (hold_v) begin
               chk("hold_adr", o_wb_adr, h_adr);
               chk("hold_cti", o_wb_cti, h_cti);
               chk("hold_dat", o_wb_dat, h_dat);
            end
            if (wcnt < 0) wcnt = (wq.size() != 0) ? wq.pop_front() : 0;
            if (wcnt == 0) begin
               i_wb_ack = 1'b1;
               wcnt = -1;
               hold_v = 1'b0;
               if (exp_beats.size() == 0) begin
                  miss("wb_beat_extra", o_wb_adr);
                  i_wb_dat = 32'hDEAD_BEEF;
               end else begin
                  be = exp_beats.pop_front();
                  chk("wb_adr", o_wb_adr, be.adr);
                  chk("wb_we", o_wb_we, be.we);
                  chk("wb_cti", o_wb_cti, be.cti);
                  chk("wb_sel", o_wb_sel, 4'hF);
                  chk("wb_bte", o_wb_bte, 2'b00);
                  if (be.we) chk("wb_dat", o_wb_dat, be.dat);
                  i_wb_dat = be.rdat;
               end
            end else begin
               i_wb_ack = 1'b0;
               i_wb_dat = 32'hDEAD_BEEF;
               wcnt--;
               hold_v = 1'b1;
               h_adr = o_wb_adr;
               h_cti = o_wb_cti;
               h_dat = o_wb_dat;
            end
         end else begin
            i_wb_ack = stray;
            i_wb_dat = 32'hDEAD_BEEF;
            hold_v = 1'b0;
         end
      end
   end

   task automatic push_exp(input vec_t v);
      beat_t b;
      ramw_t r;
      logic [31:0] w;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] kb;
         kb = 2'(k);
         w = v.data[32*k +: 32];
         b.adr  = {v.adr, kb, 2'b00};
         b.we   = v.is_ev;
         b.dat  = v.is_ev ? w : 32'h0;
         b.cti  = (k == 3) ? 3'b111 : 3'b010;
         b.rdat = v.is_ev ? 32'h0 : w;
         exp_beats.push_back(b);
         wq.push_back(int'(v.waits[4*k +: 4]));
         if (!v.is_ev) begin
            r.ben   = 16'h000F << (4*k);
            r.waddr = v.idx;
            r.wdata = {4{w}};
            exp_ram.push_back(r);
         end
      end
      if (v.is_ev) begin
         mem[v.idx] = v.data;
         exp_raddr.push_back(v.idx);
      end
   endtask

   task automatic wait_done(input int bound, output int cycles);
      cycles = 0;
      while (!o_done && cycles < bound) begin
         @(negedge i_clk);
         cycles++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc_n, d0;
      push_exp(v);
      d0 = done_cnt;
      @(negedge i_clk);
      if (v.is_ev) begin
         i_evict_req = 1'b1; i_evict_adr = v.adr; i_evict_idx = v.idx;
      end else begin
         i_fill_req = 1'b1; i_fill_adr = v.adr; i_fill_idx = v.idx;
      end
      @(negedge i_clk);
      i_evict_req = 1'b0;
      i_fill_req  = 1'b0;
      chk("busy_rise", o_busy, 1'b1);
      chk("cyc_rise", o_wb_cyc, !v.is_ev);
      chk("ren_rise", o_ram_ren, v.is_ev);
      cyc_n = 1;
      while (!o_done && cyc_n < v.lat + 20) begin
         @(negedge i_clk);
         cyc_n++;
         if (v.poke && cyc_n == 2) begin
            i_fill_req = 1'b1;  i_fill_adr  = 28'h0DEAD00; i_fill_idx  = 5'd30;
            i_evict_req = 1'b1; i_evict_adr = 28'h0BEEF00; i_evict_idx = 5'd29;
         end else begin
            i_fill_req = 1'b0;
            i_evict_req = 1'b0;
         end
      end
      i_fill_req = 1'b0;
      i_evict_req = 1'b0;
      chk("latency", cyc_n, v.lat);
      chk("done_busy", o_busy, 1'b0);
      if (!v.is_ev) chk("done_last_ben", o_ram_ben, 16'hF000);
      @(negedge i_clk);
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_cyc", o_wb_cyc, 1'b0);
      chk("done_count", done_cnt - d0, 1);
      if (!v.is_ev) chk("line", mem[v.idx], v.data);
      if (v.poke) begin
         repeat (3) @(negedge i_clk);
         chk("poke_idle", {o_busy, o_wb_cyc, o_ram_ren}, 3'b000);
         chk("poke_done_count", done_cnt - d0, 1);
      end
      chk("queues_empty", exp_beats.size() + exp_ram.size() + exp_raddr.size(), 0);
   endtask

   vec_t tbl[6];

   initial begin : stim
      vec_t ve, vf;
      int cyc, d0;
      logic [127:0] pat;
      tbl[0] = '{1'b0, 28'h0000100, 5'd5,  128'h44444444_33333333_22222222_11111111, 16'h0000, 5,  1'b0};
      tbl[1] = '{1'b1, 28'h0000200, 5'd3,  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0000, 7,  1'b0};
      tbl[2] = '{1'b0, 28'hABCDEF0, 5'd9,  128'h0BADF00D_C0FFEE11_12345678_9ABCDEF0, 16'h0120, 8,  1'b0};
      tbl[3] = '{1'b1, 28'hFFFFFFF, 5'd31, 128'h01020304_A5A5A5A5_5A5A5A5A_FFFF0000, 16'h0301, 11, 1'b0};
      tbl[4] = '{1'b0, 28'hFFFFFFF, 5'd0,  128'h76543210_FEDCBA98_00FF00FF_13579BDF, 16'h2000, 7,  1'b1};
      tbl[5] = '{1'b1, 28'h1234567, 5'd17, 128'h11223344_55667788_99AABBCC_DDEEFF00, 16'h0000, 7,  1'b1};

      for (int i = 0; i < DEPTH; i++) mem[i] = {4{32'h5555_0000 + 32'(i)}};
      i_reset_n = 1'b0;
      i_fill_req = 1'b0;  i_fill_adr = '0;  i_fill_idx = '0;
      i_evict_req = 1'b0; i_evict_adr = '0; i_evict_idx = '0;
      i_wb_ack = 1'b0;    i_wb_dat = '0;    i_ram_rdata = '0;

      #12;
      chk("reset_ctl", {o_busy, o_done, o_ram_ben, o_ram_ren, o_wb_cyc, o_wb_stb, o_wb_we,
                        o_wb_sel, o_wb_cti, o_wb_bte, o_ram_waddr, o_ram_raddr}, '0);
      chk("reset_data", {o_wb_adr, o_wb_dat, o_ram_wdata[63:0]}, '0);
      chk("reset_wdata_hi", o_ram_wdata[127:64], '0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (2) @(negedge i_clk);

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // Both requests together: evict first, fill only after DONE
      ve = '{1'b1, 28'h0000300, 5'd12, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 16'h0000, 7, 1'b0};
      vf = '{1'b0, 28'h0000400, 5'd13, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 16'h0000, 5, 1'b0};
      push_exp(ve);
      push_exp(vf);
      d0 = done_cnt;
      @(negedge i_clk);
      i_evict_req = 1'b1; i_evict_adr = ve.adr; i_evict_idx = ve.idx;
      i_fill_req  = 1'b1; i_fill_adr  = vf.adr; i_fill_idx  = vf.idx;
      @(negedge i_clk);
      i_evict_req = 1'b0;
      chk("both_evict_first", {o_ram_ren, o_wb_cyc}, 2'b10);
      wait_done(40, cyc);
      chk("both_evict_done", o_done, 1'b1);
      cyc = 0;
      while (!o_busy && cyc < 10) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("both_fill_gap", cyc, 2);
      i_fill_req = 1'b0;
      wait_done(40, cyc);
      chk("both_fill_lat", cyc, 4);
      @(negedge i_clk);
      chk("both_done_count", done_cnt - d0, 2);
      chk("both_fill_line", mem[vf.idx], vf.data);
      chk("both_queues", exp_beats.size() + exp_ram.size() + exp_raddr.size(), 0);

      // Reset after the second fill ack: bytes 15:8 stay untouched, no o_done
      pat = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      mem[7] = pat;
      vf = '{1'b0, 28'h0000500, 5'd7, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 16'h0000, 5, 1'b0};
      push_exp(vf);
      d0 = done_cnt;
      @(negedge i_clk);
      i_fill_req = 1'b1; i_fill_adr = vf.adr; i_fill_idx = vf.idx;
      @(negedge i_clk);
      i_fill_req = 1'b0;
      repeat (2) @(negedge i_clk);
      #2 i_reset_n = 1'b0;
      #1;
      chk("async_reset_ctl", {o_busy, o_done, o_ram_ben, o_ram_ren, o_wb_cyc, o_wb_stb, o_wb_we,
                              o_wb_sel, o_wb_cti}, '0);
      chk("async_reset_data", {o_wb_adr, o_wb_dat, o_ram_wdata[63:0]}, '0);
      exp_beats.delete();
      exp_ram.delete();
      wq.delete();
      wcnt = -1;
      hold_v = 1'b0;
      @(negedge i_clk);
      #1 i_reset_n = 1'b1;
      chk("partial_line_hi", mem[7][127:64], pat[127:64]);
      chk("partial_line_lo", mem[7][63:0], vf.data[63:0]);
      // stray acks while idle must not start anything
      stray = 1'b1;
      repeat (3) @(negedge i_clk);
      stray = 1'b0;
      @(negedge i_clk);
      chk("stray_ack_idle", {o_busy, o_wb_cyc, o_ram_ben}, '0);
      chk("reset_no_done", done_cnt - d0, 0);

      vf.data = 128'h9C9C9C9C_8B8B8B8B_7A7A7A7A_69696969;
      vf.waits = 16'h0102;
      vf.lat = 8;
      run_vec(vf);

      repeat (2) @(negedge i_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
